mac_operand_pipe: RTL and testbench
===================================

// Module: mac_operand_pipe
// PURPOSE
//  - Parametrised elastic operand pipeline between the MAC input capture logic and the multiplier.
//  - Carries operand A, operand B and the clear_mult/signed_mode sideband through DEPTH stages.
//  - Each stage has a valid/ready handshake, so the multiplier can stall without dropping operands.
//  - Bubbles collapse. A synchronous flush empties the pipe.
// PARAMETERS
//  A_WIDTH  8  operand A width, >=1
//  B_WIDTH  8  operand B width, >=1
//  DEPTH    2  number of register stages, >=1; elaboration error if <1
// PORTS
//  clk             in   1                  rising-edge clock
//  rst             in   1                  reset, synchronous, active-high
//  flush           in   1                  synchronous pipe clear; has priority over all traffic
//  in_valid        in   1                  upstream offers a beat
//  in_ready        out  1                  stage 0 can accept a beat
//  in_data_a       in   A_WIDTH            operand A
//  in_data_b       in   B_WIDTH            operand B
//  in_clear_mult   in   1                  sideband: clear accumulator with this beat
//  in_signed_mode  in   1                  sideband: signed multiply for this beat
//  out_valid       out  1                  last stage holds a beat
//  out_ready       in   1                  downstream accepts the beat
//  out_data_a      out  A_WIDTH            last stage operand A
//  out_data_b      out  B_WIDTH            last stage operand B
//  out_clear_mult  out  1                  last stage sideband
//  out_signed_mode out  1                  last stage sideband
//  occupancy       out  $clog2(DEPTH+1)    beats held; present only with MAC_PIPE_OCCUPANCY_EN
// BEHAVIOUR
//  - Reset is synchronous, active-high, on clk.
//  - Reset values: every stage valid=0; every data and sideband register=0.
//    So out_valid=0, out_* data=0, occupancy=0. in_ready=1 from the first cycle after reset deasserts.
//  - Handshake, stage s: ready[s] = ~valid[s] | ready[s+1]; ready[DEPTH] = out_ready.
//    in_ready = ready[0] & ~flush. A transfer occurs when valid and ready are both high on a rising edge.
//  - Stage load: stage s captures stage s-1 (stage 0 captures in_*) when ready[s] is high.
//    Stage s valid <= valid[s-1] (stage 0: in_valid & ~flush).
//    If ready[s] is low, the stage holds data and valid unchanged.
//  - Latency: DEPTH cycles from an in_* transfer to out_valid when the pipe is empty.
//    Throughput: 1 beat per cycle while out_ready=1.
//  - Stall: with out_ready=0 the pipe fills. in_ready drops only when all DEPTH stages are valid.
//    A full pipe holds exactly DEPTH beats and loses or duplicates none.
//  - Bubble collapse: a stage with valid=0 accepts even when downstream is stalled.
//  - Stability: while out_valid=1 and out_ready=0, all out_* signals stay stable.
//  - Flush: on the next edge every valid clears to 0 and data registers hold their values.
//    An in_valid beat offered in the flush cycle is not accepted (in_ready=0).
//    flush together with rst behaves as rst.
//  - Reset mid-operation discards all beats. No partial beat reaches the output.
//  - Sideband bits travel with their operands and are never combined across beats.
//  - in_ready depends combinationally on out_ready through DEPTH AND/OR levels. This path is accepted.
// CONFIGURATION
//  - MAC_PIPE_OCCUPANCY_EN defined: the occupancy port exists.
//    occupancy = number of valid stages, registered, range 0..DEPTH, updated the same edge as the valids.
//    Reset and flush drive it to 0.
//  - MAC_PIPE_OCCUPANCY_EN undefined: no occupancy port and no counter logic. All other behaviour is identical.
// STRUCTURE
//  - mac_pkg:
//    - MAC_A_WIDTH_DEF=8 and MAC_B_WIDTH_DEF=8
//    - MAC_SIDEBAND_W=2
//    - sideband bit indices MAC_SB_CLEAR=0 and MAC_SB_SIGNED=1
//  - Sub-module mac_pipe_stage:
//    - one valid/data register stage, payload width A_WIDTH+B_WIDTH+MAC_SIDEBAND_W
//    - ports: clk, rst, flush, up_valid, up_ready, up_data, dn_valid, dn_ready, dn_data
//    - instantiated DEPTH times in a generate loop
// TESTING
//  1. DEPTH=2; rst held 3 cycles, then released -> out_valid=0, out_data_a=0, in_ready=1 in the first cycle after release.
//  2. DEPTH=2; out_ready=1; stream A=0x01..0x10 and B=0xF0..0xFF, one beat per cycle ->
//     the same 16 pairs appear in order, first at cycle 2, with no gaps.
//  3. DEPTH=3; out_ready=0; offer A=0x11, 0x22, 0x33, 0x44 ->
//     in_ready=0 after 3 accepts; A=0x44 is held until out_ready=1; outputs then 0x11, 0x22, 0x33, 0x44.
//  4. DEPTH=2; beat A=0x7F with clear_mult=1, signed_mode=1, then A=0x80 with both sidebands 0 ->
//     the output sidebands are 1,1 then 0,0, aligned with their operands.
//  5. DEPTH=2; pipe full and out_ready=0; assert flush for 1 cycle together with in_valid=1 (A=0x55) ->
//     out_valid=0 on the next cycle, 0x55 is never output, and occupancy=0 under MAC_PIPE_OCCUPANCY_EN.
//  6. DEPTH=2; assert rst while 2 beats are in flight and out_ready toggles ->
//     all valids 0 after the edge, no stale beat emerges, and occupancy=0.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg
//   Shared constants for the MAC operand pipeline slice.
//   Default operand widths, the width of the per-beat sideband field and the
//   bit positions of each sideband flag inside that field.
//   Optional feature macro used by this slice: MAC_PIPE_OCCUPANCY_EN.
package mac_pkg;

  localparam int MAC_A_WIDTH_DEF = 8;
  localparam int MAC_B_WIDTH_DEF = 8;

  localparam int MAC_SIDEBAND_W  = 2;
  localparam int MAC_SB_CLEAR    = 0;
  localparam int MAC_SB_SIGNED   = 1;

endpackage

// File: rtl/mac_pipe_stage.sv
// mac_pipe_stage
//   One elastic register stage holding a valid bit and a packed payload.
//   The stage accepts a new beat whenever it is empty or its own beat is leaving
//   this cycle, so bubbles collapse even while the downstream side is stalled.
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset, clears valid and payload
//   flush     in   synchronous clear of valid, payload is kept
//   up_valid  in   upstream offers a beat
//   up_ready  out  this stage can take a beat this cycle
//   up_data   in   upstream payload
//   dn_valid  out  this stage holds a beat
//   dn_ready  in   downstream takes the held beat
//   dn_data   out  held payload
import mac_pkg::*;

module mac_pipe_stage #(
  parameter int W = MAC_A_WIDTH_DEF + MAC_B_WIDTH_DEF + MAC_SIDEBAND_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next-state for the stage. Flush only drops the valid bit; the payload is
  // left alone because nothing downstream looks at it while valid is low.
  // When ready, the payload is captured even for an empty upstream slot.
  always_comb begin
    up_ready = ~valid_q | dn_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (up_ready) begin
      valid_d = up_valid;
      data_d  = up_data;
    end
  end

  // Stage register with synchronous reset of both valid and payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/mac_operand_pipe.sv
// mac_operand_pipe
//   Elastic operand pipeline between MAC input capture and the multiplier.
//   Operand A, operand B and the clear_mult/signed_mode sideband travel as one
//   packed payload through DEPTH mac_pipe_stage instances.
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   flush                     synchronous pipe clear, beats in flight are dropped
//   in_valid / in_ready       upstream handshake (in_ready is low during flush)
//   in_data_a, in_data_b      operands
//   in_clear_mult             sideband: clear accumulator with this beat
//   in_signed_mode            sideband: signed multiply for this beat
//   out_valid / out_ready     downstream handshake
//   out_data_a, out_data_b    last-stage operands
//   out_clear_mult            last-stage sideband
//   out_signed_mode           last-stage sideband
//   occupancy                 number of valid stages, only when MAC_PIPE_OCCUPANCY_EN
//                             is defined
// Configuration
//   MAC_PIPE_OCCUPANCY_EN     adds the registered occupancy port and its counter
import mac_pkg::*;

module mac_operand_pipe #(
  parameter int A_WIDTH = MAC_A_WIDTH_DEF,
  parameter int B_WIDTH = MAC_B_WIDTH_DEF,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_data_a,
  input  logic [B_WIDTH-1:0] in_data_b,
  input  logic               in_clear_mult,
  input  logic               in_signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH-1:0] out_data_a,
  output logic [B_WIDTH-1:0] out_data_b,
  output logic               out_clear_mult,
  output logic               out_signed_mode
`ifdef MAC_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  localparam int PW = A_WIDTH + B_WIDTH + MAC_SIDEBAND_W;

  if (DEPTH < 1) begin : g_bad_depth
    $error("mac_operand_pipe: DEPTH must be at least 1");
  end

  logic [MAC_SIDEBAND_W-1:0] in_sb;
  logic [PW-1:0]             in_payload;
  logic [PW-1:0]             out_payload;

  // Sideband flags are placed by index so their position is defined in one place.
  always_comb begin
    in_sb                = '0;
    in_sb[MAC_SB_CLEAR]  = in_clear_mult;
    in_sb[MAC_SB_SIGNED] = in_signed_mode;
  end

  assign in_payload = {in_data_a, in_data_b, in_sb};

  // Each stage gets its own named wires so the ready chain, which runs
  // combinationally from out_ready back to in_ready, is a chain of distinct
  // nets rather than bits of one shared vector.
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    logic          up_valid_w;
    logic          up_ready_w;
    logic [PW-1:0] up_data_w;
    logic          dn_valid_w;
    logic          dn_ready_w;
    logic [PW-1:0] dn_data_w;

    if (s == 0) begin : g_first
      assign up_valid_w = in_valid & ~flush;
      assign up_data_w  = in_payload;
    end else begin : g_chain
      assign up_valid_w = g_stage[s-1].dn_valid_w;
      assign up_data_w  = g_stage[s-1].dn_data_w;
    end

    if (s == DEPTH - 1) begin : g_last
      assign dn_ready_w = out_ready;
    end else begin : g_inner
      assign dn_ready_w = g_stage[s+1].up_ready_w;
    end

    mac_pipe_stage #(
      .W (PW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_valid_w),
      .up_ready (up_ready_w),
      .up_data  (up_data_w),
      .dn_valid (dn_valid_w),
      .dn_ready (dn_ready_w),
      .dn_data  (dn_data_w)
    );
  end

  assign in_ready    = g_stage[0].up_ready_w & ~flush;
  assign out_valid   = g_stage[DEPTH-1].dn_valid_w;
  assign out_payload = g_stage[DEPTH-1].dn_data_w;

  assign out_data_a      = out_payload[PW-1 -: A_WIDTH];
  assign out_data_b      = out_payload[MAC_SIDEBAND_W +: B_WIDTH];
  assign out_clear_mult  = out_payload[MAC_SB_CLEAR];
  assign out_signed_mode = out_payload[MAC_SB_SIGNED];

`ifdef MAC_PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             in_fire;
  logic             out_fire;

  // Beats only enter at stage 0 and leave at the last stage; moves between
  // stages never change the count, so an up/down counter tracks the number
  // of valid stages exactly.
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    occ_d    = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
  end

  // Occupancy register, updated on the same edge as the stage valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_mac_operand_pipe.sv
// tb_mac_operand_pipe
//   Directed bench for mac_operand_pipe. A DEPTH=2 instance covers reset,
//   streaming, sideband alignment, flush and mid-flight reset; a DEPTH=3
//   instance covers the full-pipe stall. Occupancy is checked when
//   MAC_PIPE_OCCUPANCY_EN is defined.
module tb_mac_operand_pipe;

  logic       clk;
  logic       rst;

  logic       flush2;
  logic       inValid2;
  logic       inReady2;
  logic [7:0] inA2;
  logic [7:0] inB2;
  logic       inClr2;
  logic       inSgn2;
  logic       outValid2;
  logic       outReady2;
  logic [7:0] outA2;
  logic [7:0] outB2;
  logic       outClr2;
  logic       outSgn2;

  logic       flush3;
  logic       inValid3;
  logic       inReady3;
  logic [7:0] inA3;
  logic [7:0] inB3;
  logic       inClr3;
  logic       inSgn3;
  logic       outValid3;
  logic       outReady3;
  logic [7:0] outA3;
  logic [7:0] outB3;
  logic       outClr3;
  logic       outSgn3;

`ifdef MAC_PIPE_OCCUPANCY_EN
  logic [1:0] occ2;
  logic [1:0] occ3;
`endif

  int checkCount;
  int failCount;

  mac_operand_pipe #(
    .A_WIDTH (8),
    .B_WIDTH (8),
    .DEPTH   (2)
  ) dut2 (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush2),
    .in_valid        (inValid2),
    .in_ready        (inReady2),
    .in_data_a       (inA2),
    .in_data_b       (inB2),
    .in_clear_mult   (inClr2),
    .in_signed_mode  (inSgn2),
    .out_valid       (outValid2),
    .out_ready       (outReady2),
    .out_data_a      (outA2),
    .out_data_b      (outB2),
    .out_clear_mult  (outClr2),
    .out_signed_mode (outSgn2)
`ifdef MAC_PIPE_OCCUPANCY_EN
    ,
    .occupancy       (occ2)
`endif
  );

  mac_operand_pipe #(
    .A_WIDTH (8),
    .B_WIDTH (8),
    .DEPTH   (3)
  ) dut3 (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush3),
    .in_valid        (inValid3),
    .in_ready        (inReady3),
    .in_data_a       (inA3),
    .in_data_b       (inB3),
    .in_clear_mult   (inClr3),
    .in_signed_mode  (inSgn3),
    .out_valid       (outValid3),
    .out_ready       (outReady3),
    .out_data_a      (outA3),
    .out_data_b      (outB3),
    .out_clear_mult  (outClr3),
    .out_signed_mode (outSgn3)
`ifdef MAC_PIPE_OCCUPANCY_EN
    ,
    .occupancy       (occ3)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a wedged run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one beat (or an idle slot) on the DEPTH=2 instance.
  task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                               input logic clr, input logic sgn);
    inValid2 = valid;
    inA2     = a;
    inB2     = b;
    inClr2   = clr;
    inSgn2   = sgn;
  endtask

  // Advances to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    logic [7:0] vals3 [4];
    logic [7:0] expA4 [2];
    logic       expSb4 [2];
    int         nOut;
    int         accepted;
    logic       got;
    logic       fire;

    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    flush2     = 1'b0;
    outReady2  = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    flush3     = 1'b0;
    inValid3   = 1'b0;
    inA3       = 8'h00;
    inB3       = 8'h00;
    inClr3     = 1'b0;
    inSgn3     = 1'b0;
    outReady3  = 1'b0;

    $display("[TB] test 1: reset");
    repeat (3) step();
    rst = 1'b0;
    #1;
    checkOutput("t1_out_valid", 32'(outValid2), 32'd0);
    checkOutput("t1_out_a", 32'(outA2), 32'd0);
    checkOutput("t1_in_ready", 32'(inReady2), 32'd1);
    checkOutput("t1_in_ready3", 32'(inReady3), 32'd1);
`ifdef MAC_PIPE_OCCUPANCY_EN
    checkOutput("t1_occ", 32'(occ2), 32'd0);
`endif
    step();

    $display("[TB] test 2: streaming");
    outReady2 = 1'b1;
    nOut = 0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      if (cyc < 16) applyStimulus(1'b1, 8'(cyc + 1), 8'(8'hF0 + cyc), 1'b0, 1'b0);
      else          applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      #1;
      if (cyc < 16) checkOutput("t2_in_ready", 32'(inReady2), 32'd1);
      if (outValid2) begin
        if (nOut < 16) begin
          checkOutput("t2_a", 32'(outA2), 32'(nOut + 1));
          checkOutput("t2_b", 32'(outB2), 32'(8'hF0 + nOut));
          checkOutput("t2_cycle", 32'(cyc), 32'(nOut + 2));
        end else begin
          checkOutput("t2_extra_beat", 32'(outValid2), 32'd0);
        end
        nOut++;
      end
      step();
    end
    checkOutput("t2_count", 32'(nOut), 32'd16);

    $display("[TB] test 3: DEPTH=3 stall");
    vals3[0] = 8'h11;
    vals3[1] = 8'h22;
    vals3[2] = 8'h33;
    vals3[3] = 8'h44;
    outReady3 = 1'b0;
    accepted = 0;
    for (int k = 0; k < 3; k++) begin
      inValid3 = 1'b1;
      inA3     = vals3[k];
      got      = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        #1;
        got = inReady3;
        step();
      end
      checkOutput("t3_accept", 32'(got), 32'd1);
      if (got) accepted++;
    end
    inA3 = vals3[3];
    #1;
    checkOutput("t3_full_in_ready", 32'(inReady3), 32'd0);
    step();
    step();
    #1;
    checkOutput("t3_held_in_ready", 32'(inReady3), 32'd0);
    checkOutput("t3_stall_valid", 32'(outValid3), 32'd1);
    checkOutput("t3_stall_a", 32'(outA3), 32'h11);
`ifdef MAC_PIPE_OCCUPANCY_EN
    checkOutput("t3_occ_full", 32'(occ3), 32'd3);
`endif
    step();
    outReady3 = 1'b1;
    nOut = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      #1;
      fire = inValid3 & inReady3;
      if (outValid3) begin
        if (nOut < 4) checkOutput("t3_out_a", 32'(outA3), 32'(vals3[nOut]));
        else          checkOutput("t3_extra_beat", 32'(outValid3), 32'd0);
        nOut++;
      end
      step();
      if (fire) inValid3 = 1'b0;
    end
    checkOutput("t3_count", 32'(nOut), 32'd4);

    $display("[TB] test 4: sideband alignment");
    expA4[0]  = 8'h7F;
    expA4[1]  = 8'h80;
    expSb4[0] = 1'b1;
    expSb4[1] = 1'b0;
    outReady2 = 1'b1;
    nOut = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 0)      applyStimulus(1'b1, 8'h7F, 8'h03, 1'b1, 1'b1);
      else if (cyc == 1) applyStimulus(1'b1, 8'h80, 8'h04, 1'b0, 1'b0);
      else               applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      #1;
      if (outValid2) begin
        if (nOut < 2) begin
          checkOutput("t4_a", 32'(outA2), 32'(expA4[nOut]));
          checkOutput("t4_clear", 32'(outClr2), 32'(expSb4[nOut]));
          checkOutput("t4_signed", 32'(outSgn2), 32'(expSb4[nOut]));
        end else begin
          checkOutput("t4_extra_beat", 32'(outValid2), 32'd0);
        end
        nOut++;
      end
      step();
    end
    checkOutput("t4_count", 32'(nOut), 32'd2);

    $display("[TB] test 5: flush");
    outReady2 = 1'b0;
    applyStimulus(1'b1, 8'hA1, 8'h01, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 8'hA2, 8'h02, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("t5_full_in_ready", 32'(inReady2), 32'd0);
    checkOutput("t5_full_valid", 32'(outValid2), 32'd1);
    checkOutput("t5_full_a", 32'(outA2), 32'hA1);
`ifdef MAC_PIPE_OCCUPANCY_EN
    checkOutput("t5_occ_full", 32'(occ2), 32'd2);
`endif
    step();
    applyStimulus(1'b1, 8'h55, 8'h66, 1'b0, 1'b0);
    flush2 = 1'b1;
    #1;
    checkOutput("t5_flush_in_ready", 32'(inReady2), 32'd0);
    step();
    flush2 = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("t5_after_valid", 32'(outValid2), 32'd0);
    checkOutput("t5_after_in_ready", 32'(inReady2), 32'd1);
`ifdef MAC_PIPE_OCCUPANCY_EN
    checkOutput("t5_occ_after", 32'(occ2), 32'd0);
`endif
    outReady2 = 1'b1;
    nOut = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      #1;
      if (outValid2) nOut++;
    end
    checkOutput("t5_no_leak", 32'(nOut), 32'd0);

    $display("[TB] test 6: reset mid-flight");
    outReady2 = 1'b0;
    applyStimulus(1'b1, 8'hB1, 8'h11, 1'b1, 1'b0);
    step();
    outReady2 = 1'b1;
    applyStimulus(1'b1, 8'hB2, 8'h12, 1'b0, 1'b1);
    step();
    outReady2 = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("t6_inflight_valid", 32'(outValid2), 32'd1);
    checkOutput("t6_inflight_a", 32'(outA2), 32'hB1);
`ifdef MAC_PIPE_OCCUPANCY_EN
    checkOutput("t6_occ_inflight", 32'(occ2), 32'd2);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("t6_reset_valid", 32'(outValid2), 32'd0);
    checkOutput("t6_reset_a", 32'(outA2), 32'd0);
    checkOutput("t6_reset_in_ready", 32'(inReady2), 32'd1);
`ifdef MAC_PIPE_OCCUPANCY_EN
    checkOutput("t6_occ_reset", 32'(occ2), 32'd0);
`endif
    outReady2 = 1'b1;
    nOut = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      #1;
      if (outValid2) nOut++;
    end
    checkOutput("t6_no_stale", 32'(nOut), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
